// File: rtl/song_reader.sv
// Song sequencer: walks a 32-entry song ROM, hands each note/duration pair to
// the note player with a one-cycle strobe, and waits for note_done before advancing.

module song_rom (
  input  logic        clk,
  input  logic [6:0]  addr,
  output logic [11:0] data
);
  // Contents are {note[5:0], duration[5:0]}; a zero duration marks end of song.
  function automatic logic [11:0] rom_word(input logic [1:0] s, input logic [4:0] i);
    logic [5:0] n;
    logic [5:0] d;
    n = '0;
    d = '0;
    case (s)
      2'd0: begin
        if (i == 5'd0) begin
          n = 6'd10;
          d = 6'd4;
        end else if (i == 5'd1) begin
          n = 6'd20;
          d = 6'd2;
        end else begin
          n = {1'b0, i} + 6'd30;
          d = 6'(i % 5'd3) + 6'd1;
        end
      end
      2'd1: begin
        if (i < 5'd3) begin
          n = {1'b0, i} + 6'd40;
          d = 6'd3;
        end
      end
      2'd2: begin
        n = (i[2:0] == 3'd4) ? 6'd0 : 6'd63 - {1'b0, i};
        d = {4'b0, i[1:0]} + 6'd1;
      end
      default: begin
        n = '0;
        d = '0;
      end
    endcase
    return {n, d};
  endfunction

  always_ff @(posedge clk) begin
    data <= rom_word(addr[6:5], addr[4:0]);
  end
endmodule

module song_reader #(
  parameter int SONG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [1:0] song,
  input  logic       note_done,
  output logic [5:0] note,
  output logic [5:0] duration,
  output logic       new_note,
  output logic       song_done,
  output logic [4:0] note_index
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_ROM  = 3'd2;
  localparam logic [2:0] S_LOAD      = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_PAUSED    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [4:0] LAST_INDEX = 5'(SONG_LEN - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [1:0]  song_q;
  logic [4:0]  index;
  logic [11:0] rom_data;
  logic        song_change;

  song_rom u_rom (
    .clk  (clk),
    .addr ({song_q, index}),
    .data (rom_data)
  );

  // A song switch only matters once a song has been latched and is still running.
  assign song_change = (song != song_q) && (state != S_IDLE) && (state != S_DONE);

  // Handshake to note_player: new_note is a one-cycle strobe with note/duration
  // valid in the same cycle; note_done is a one-cycle reply, only honoured in WAIT_DONE.
  assign new_note   = (state == S_LOAD);
  assign note_index = index;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (play) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (song_change)  state_nxt = S_IDLE;
        else if (!play)   state_nxt = S_PAUSED;
        else              state_nxt = S_WAIT_ROM;
      end
      S_WAIT_ROM: begin
        if (song_change)                state_nxt = S_IDLE;
        else if (!play)                 state_nxt = S_PAUSED;
        else if (rom_data[5:0] == 6'd0) state_nxt = S_DONE;
        else                            state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (song_change)  state_nxt = S_IDLE;
        else if (!play)   state_nxt = S_PAUSED;
        else              state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (song_change)  state_nxt = S_IDLE;
        else if (!play)   state_nxt = S_PAUSED;
        else if (note_done) begin
          state_nxt = (index == LAST_INDEX) ? S_DONE : S_FETCH;
        end
      end
      S_PAUSED: begin
        // Resume re-fetches the same note since the player cleared itself.
        if (song_change)  state_nxt = S_IDLE;
        else if (play)    state_nxt = S_FETCH;
      end
      S_DONE: begin
        if (!play || (song != song_q)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      song_q    <= 2'd0;
      index     <= 5'd0;
      note      <= 6'd0;
      duration  <= 6'd0;
      song_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      song_done <= (state_nxt == S_DONE) && (state != S_DONE);

      if ((state == S_IDLE) && (state_nxt == S_FETCH)) begin
        song_q <= song;
      end

      if (song_change || (state_nxt == S_DONE)) begin
        index <= 5'd0;
      end else if ((state == S_WAIT_DONE) && (state_nxt == S_FETCH)) begin
        index <= index + 5'd1;
      end

      if ((state == S_WAIT_ROM) && (state_nxt == S_LOAD)) begin
        note     <= rom_data[11:6];
        duration <= rom_data[5:0];
      end
    end
  end
endmodule
